demux_1xn_stream: RTL



---
 rtl/demux_1xn_stream_pkg.sv | 23 ++
 rtl/demux_1xn_stream_if.sv | 31 +++
 rtl/demux_1xn_stream_chan_reg.sv | 36 +++
 rtl/demux_1xn_stream.sv | 78 +++++++
 4 files changed

// File: rtl/demux_1xn_stream_pkg.sv
// Shared defaults, channel state encoding and the out_data slice helper
// for the 1-to-N registered stream demultiplexer.
`ifndef DEMUX_1XN_STREAM_PKG_SV
`define DEMUX_1XN_STREAM_PKG_SV

// Bit range of channel k inside a flattened N*w output bus.
`define DMX_SLICE(k, w) [(k)*(w) +: (w)]

package demux_1xn_stream_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SELW  = 4;
    localparam int DEF_CNTW  = 8;

    typedef logic [0:0] chan_state_t;

    localparam chan_state_t ST_EMPTY = 1'b0;
    localparam chan_state_t ST_FULL  = 1'b1;

endpackage

`endif

// File: rtl/demux_1xn_stream_if.sv
// Producer/consumer bundle of the demultiplexer. Handshake: a word moves on
// every rising edge where valid & ready are both high; ready never depends on valid.
interface demux_1xn_stream_if
    import demux_1xn_stream_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SELW  = DEF_SELW,
    parameter int CNTW  = DEF_CNTW
);
    logic [WIDTH-1:0]   in_data;
    logic [SELW-1:0]    in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic               sel_err;
    logic [CNTW-1:0]    drop_cnt;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, drop_cnt
    );
endinterface

// File: rtl/demux_1xn_stream_chan_reg.sv
// One-entry valid/ready output register. A FULL channel that drains and
// reloads on the same edge stays FULL with the new word.
module demux_chan_reg
    import demux_1xn_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_free,
    output chan_state_t      o_state,
    output logic [WIDTH-1:0] o_data
);
    chan_state_t      r_state;
    logic [WIDTH-1:0] r_data;

    assign o_free  = (r_state == ST_EMPTY) | i_ready;
    assign o_state = r_state;
    assign o_data  = r_data;

    // i_load is only raised by the parent when o_free is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= ST_FULL;
            r_data  <= i_data;
        end else if ((r_state == ST_FULL) && i_ready) begin
            r_state <= ST_EMPTY;
        end
    end
endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer with routed and broadcast modes;
// out-of-range routed words are accepted, dropped and counted.
module demux_1xn_stream
    import demux_1xn_stream_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SELW  = DEF_SELW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_1xn_stream_if.slave   bus
);
    logic [N-1:0]    w_free;
    logic [N-1:0]    w_hit;
    logic [N-1:0]    w_load;
    chan_state_t     w_state [N];
    logic [WIDTH-1:0] w_data [N];
    logic            w_sel_ok;
    logic            w_route_rdy;
    logic            w_in_ready;
    logic            w_xfer;
    logic            w_drop;
    logic            r_sel_err;
    logic [CNTW-1:0] r_drop_cnt;

    // Widened compare so N == 2**SELW is handled without overflow.
    assign w_sel_ok = ({1'b0, bus.in_sel} < (SELW+1)'(N));

    always_comb begin
        w_route_rdy = 1'b0;
        w_hit       = '0;
        for (int k = 0; k < N; k++) begin
            w_hit[k]    = (bus.in_sel == SELW'(k));
            w_route_rdy = w_route_rdy | (w_hit[k] & w_free[k]);
        end
    end

    assign w_in_ready = rst_n & (bus.in_bcast ? (&w_free)
                                              : (w_sel_ok ? w_route_rdy : 1'b1));
    assign w_xfer     = bus.in_valid & w_in_ready;
    assign w_load     = {N{w_xfer}} & ({N{bus.in_bcast}} | w_hit);
    assign w_drop     = w_xfer & ~bus.in_bcast & ~w_sel_ok;

    generate
        for (genvar g = 0; g < N; g++) begin : g_chan
            demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[g]),
                .i_data  (bus.in_data),
                .i_ready (bus.out_ready[g]),
                .o_free  (w_free[g]),
                .o_state (w_state[g]),
                .o_data  (w_data[g])
            );
            assign bus.out_valid[g]                  = (w_state[g] == ST_FULL);
            assign bus.out_data `DMX_SLICE(g, WIDTH) = w_data[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_sel_err <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNTW'(1);
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.sel_err  = r_sel_err;
    assign bus.drop_cnt = r_drop_cnt;
endmodule
